ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter_if.sv | 27 ++
 rtl/ahb_arbiter.sv | 98 +++++++++
 tb/tb_ahb_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_if.sv
// AHB arbitration bus bundle: master request/lock/priority inputs and the arbiter's grant outputs.
interface ahb_arbiter_if #(
  parameter int MASTER_NUM = 4,
  parameter int PRIORBIT   = 3
);
  localparam int MW = $clog2(MASTER_NUM);

  logic [MASTER_NUM-1:0]          hbusreq;
  logic [MASTER_NUM-1:0]          hlock;
  logic [MASTER_NUM*PRIORBIT-1:0] prio;
  logic [1:0]                     htrans;
  logic                           hready;
  logic [MASTER_NUM-1:0]          hgrant;
  logic [MW-1:0]                  hmaster;
  logic [MW-1:0]                  hmaster_d;
  logic                           hmastlock;

  modport master (
    output hbusreq, hlock, prio, htrans, hready,
    input  hgrant, hmaster, hmaster_d, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, prio, htrans, hready,
    output hgrant, hmaster, hmaster_d, hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: priority selection with round-robin tie-break, locked sequences and a parked default master.
module ahb_arbiter #(
  parameter int MASTER_NUM     = 4,
  parameter int PRIORBIT       = 3,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic         hclk,
  input  logic         hreset,
  ahb_arbiter_if.slave bus
);

  localparam int MW = $clog2(MASTER_NUM);
  localparam logic [MW-1:0]         DEF = MW'(DEFAULT_MASTER);
  localparam logic [MASTER_NUM-1:0] ONE = MASTER_NUM'(1);

  localparam logic [1:0] PARK = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] LOCK = 2'd2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [1:0]            state_q;
  logic [MW-1:0]         hmaster_q;
  logic [MW-1:0]         hmaster_d_q;
  logic [MASTER_NUM-1:0] hgrant_q;

  logic [PRIORBIT-1:0]   prio_arr [MASTER_NUM];
  logic                  win_found;
  logic [MW-1:0]         win_idx;
  logic [PRIORBIT-1:0]   win_prio;
  logic [MW-1:0]         idx;
  logic                  arb_point;
  logic                  trans_idle;
  logic                  trans_nonseq;

  for (genvar g = 0; g < MASTER_NUM; g++) begin : g_prio
    assign prio_arr[g] = bus.prio[g*PRIORBIT +: PRIORBIT];
  end

  // Scan from hmaster+1 with wrap; only a strictly higher priority displaces
  // the current best, so the first equal-priority requester in the scan wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = DEF;
    win_prio  = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= MASTER_NUM; k++) begin
      idx = MW'((32'(hmaster_q) + k) % MASTER_NUM);
      if (bus.hbusreq[idx] && (!win_found || prio_arr[idx] > win_prio)) begin
        win_found = 1'b1;
        win_idx   = idx;
        win_prio  = prio_arr[idx];
      end
    end
  end

  assign trans_idle   = (bus.htrans == HTRANS_IDLE);
  assign trans_nonseq = (bus.htrans == HTRANS_NONSEQ);

  always_comb begin
    arb_point = 1'b0;
    if (bus.hready) begin
      if (state_q == LOCK)
        arb_point = trans_idle && !bus.hlock[hmaster_q];
      else
        arb_point = trans_idle || trans_nonseq || !bus.hbusreq[hmaster_q];
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= PARK;
      hmaster_q   <= DEF;
      hmaster_d_q <= DEF;
      hgrant_q    <= ONE << DEF;
    end else if (bus.hready) begin
      hmaster_d_q <= hmaster_q;
      if (arb_point) begin
        if (!win_found) begin
          state_q   <= PARK;
          hmaster_q <= DEF;
          hgrant_q  <= ONE << DEF;
        end else begin
          state_q   <= bus.hlock[win_idx] ? LOCK : OWN;
          hmaster_q <= win_idx;
          hgrant_q  <= ONE << win_idx;
        end
      end
    end
  end

  assign bus.hgrant    = hgrant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmaster_d = hmaster_d_q;
  assign bus.hmastlock = (state_q == LOCK);

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_ahb_arbiter;

  localparam int N  = 4;
  localparam int PB = 3;
  localparam int DM = 0;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state: who owns the address phase / data phase, lock flag
  int m_owner = DM;
  int m_owner_d = DM;
  bit m_lock = 1'b0;

  ahb_arbiter_if #(.MASTER_NUM(N), .PRIORBIT(PB)) bus ();

  ahb_arbiter #(.MASTER_NUM(N), .PRIORBIT(PB), .DEFAULT_MASTER(DM)) dut (
    .hclk  (hclk),
    .hreset(hreset),
    .bus   (bus)
  );

  always #5 hclk = ~hclk;

  function automatic logic [8:0] obs();
    return {bus.hgrant, bus.hmaster, bus.hmaster_d, bus.hmastlock};
  endfunction

  function automatic logic [8:0] model_tuple();
    logic [3:0] g;
    g = 4'b0001 << m_owner;
    return {g, 2'(m_owner), 2'(m_owner_d), m_lock};
  endfunction

  // Highest priority requester; among equals, the nearest one after the owner.
  function automatic int pick(input int owner, input logic [3:0] req, input logic [11:0] pr);
    int maxp;
    int i;
    logic [11:0] p;
    p = pr;
    maxp = -1;
    for (int m = 0; m < N; m++)
      if (req[m] && int'(p[m*PB +: PB]) > maxp) maxp = int'(p[m*PB +: PB]);
    for (int d = 1; d <= N; d++) begin
      i = (owner + d) % N;
      if (req[i] && int'(p[i*PB +: PB]) == maxp) return i;
    end
    return DM;
  endfunction

  task automatic cycle();
    int  nx_owner, nx_d;
    bit  nx_lock, may;
    nx_owner = m_owner;
    nx_d     = m_owner_d;
    nx_lock  = m_lock;
    if (hreset) begin
      nx_owner = DM;
      nx_d     = DM;
      nx_lock  = 1'b0;
    end else if (bus.hready) begin
      nx_d = m_owner;
      if (m_lock) may = (bus.htrans == 2'd0) && !bus.hlock[m_owner];
      else        may = (bus.htrans == 2'd0) || (bus.htrans == 2'd2) || !bus.hbusreq[m_owner];
      if (may) begin
        if (bus.hbusreq == 4'b0000) begin
          nx_owner = DM;
          nx_lock  = 1'b0;
        end else begin
          nx_owner = pick(m_owner, bus.hbusreq, bus.prio);
          nx_lock  = bus.hlock[nx_owner];
        end
      end
    end
    @(posedge hclk);
    #1;
    m_owner   = nx_owner;
    m_owner_d = nx_d;
    m_lock    = nx_lock;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lck, input logic [1:0] tr, input logic rdy);
    bus.hbusreq = req;
    bus.hlock   = lck;
    bus.htrans  = tr;
    bus.hready  = rdy;
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    drive(4'b0000, 4'b0000, 2'd0, 1'b1);
    bus.prio = '0;
    cycle();
    cycle();
    hreset = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    hreset = 1'b1;
    bus.prio = 12'($urandom);
    drive(4'($urandom), 4'($urandom), 2'($urandom), 1'b0);
    cycle();
    exp = {4'b0001, 2'd0, 2'd0, 1'b0};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs(), exp);
    end
    hreset = 1'b0;
    drive(4'b0000, 4'b0000, 2'd0, 1'b1);
    cycle();
    n_checks++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL park_no_req: got %b expected %b", obs(), exp);
    end
  endtask

  task automatic test_tie_rr();
    logic [8:0] exp [3];
    logic [3:0] reqs [3];
    exp[0] = {4'b0010, 2'd1, 2'd0, 1'b0};
    exp[1] = {4'b1000, 2'd3, 2'd1, 1'b0};
    exp[2] = {4'b0010, 2'd1, 2'd3, 1'b0};
    reqs[0] = 4'b1110;
    reqs[1] = 4'b1100;
    reqs[2] = 4'b1010;
    do_reset();
    bus.prio = {3'd5, 3'd1, 3'd5, 3'd2};
    for (int s = 0; s < 3; s++) begin
      drive(reqs[s], 4'b0000, 2'd0, 1'b1);
      cycle();
      n_checks++;
      if (obs() !== exp[s]) begin
        n_fail++;
        $display("FAIL tie_rr step %0d: got %b expected %b", s, obs(), exp[s]);
      end
    end
  endtask

  task automatic test_seq_hold();
    logic [8:0] exp;
    logic [1:0] trs [3];
    trs[0] = 2'd3;
    trs[1] = 2'd1;
    trs[2] = 2'd3;
    do_reset();
    bus.prio = {3'd6, 3'd3, 3'd0, 3'd0};
    drive(4'b0100, 4'b0000, 2'd0, 1'b1);
    cycle();
    exp = {4'b0100, 2'd2, 2'd0, 1'b0};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL seq_first_grant: got %b expected %b", obs(), exp);
    end
    exp = {4'b0100, 2'd2, 2'd2, 1'b0};
    for (int s = 0; s < 3; s++) begin
      drive(4'b1100, 4'b0000, trs[s], 1'b1);
      cycle();
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL seq_hold step %0d: got %b expected %b", s, obs(), exp);
      end
    end
    drive(4'b1100, 4'b0000, 2'd2, 1'b1);
    cycle();
    exp = {4'b1000, 2'd3, 2'd2, 1'b0};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL seq_release: got %b expected %b", obs(), exp);
    end
  endtask

  task automatic test_lock();
    logic [8:0] exp;
    logic [3:0] lcks [4];
    logic [1:0] trs [4];
    logic       rdys [4];
    lcks[0] = 4'b0010; trs[0] = 2'd2; rdys[0] = 1'b1;
    lcks[1] = 4'b0010; trs[1] = 2'd0; rdys[1] = 1'b1;
    lcks[2] = 4'b0000; trs[2] = 2'd3; rdys[2] = 1'b1;
    lcks[3] = 4'b0000; trs[3] = 2'd0; rdys[3] = 1'b0;
    do_reset();
    bus.prio = {3'd0, 3'd0, 3'd2, 3'd7};
    drive(4'b0010, 4'b0010, 2'd0, 1'b1);
    cycle();
    exp = {4'b0010, 2'd1, 2'd0, 1'b1};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL lock_grant: got %b expected %b", obs(), exp);
    end
    exp = {4'b0010, 2'd1, 2'd1, 1'b1};
    for (int s = 0; s < 4; s++) begin
      drive(4'b0011, lcks[s], trs[s], rdys[s]);
      cycle();
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL lock_hold step %0d: got %b expected %b", s, obs(), exp);
      end
    end
    drive(4'b0011, 4'b0000, 2'd0, 1'b1);
    cycle();
    exp = {4'b0001, 2'd0, 2'd1, 1'b0};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL lock_release: got %b expected %b", obs(), exp);
    end
  endtask

  task automatic test_hready_stall();
    logic [8:0] exp;
    logic [3:0] reqs [3];
    reqs[0] = 4'b1000;
    reqs[1] = 4'b0011;
    reqs[2] = 4'b1111;
    do_reset();
    drive(4'b0100, 4'b0000, 2'd0, 1'b1);
    cycle();
    exp = {4'b0100, 2'd2, 2'd0, 1'b0};
    for (int s = 0; s < 3; s++) begin
      drive(reqs[s], 4'($urandom), 2'($urandom), 1'b0);
      cycle();
      n_checks++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL stall_hold step %0d: got %b expected %b", s, obs(), exp);
      end
    end
    drive(4'b0100, 4'b0000, 2'd0, 1'b1);
    cycle();
    exp = {4'b0100, 2'd2, 2'd2, 1'b0};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL stall_resume: got %b expected %b", obs(), exp);
    end
    drive(4'b0000, 4'b0000, 2'd0, 1'b1);
    cycle();
    exp = {4'b0001, 2'd0, 2'd2, 1'b0};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL park_default: got %b expected %b", obs(), exp);
    end
  endtask

  task automatic test_reset_in_lock();
    logic [8:0] exp;
    do_reset();
    drive(4'b0100, 4'b0100, 2'd0, 1'b1);
    cycle();
    drive(4'b0100, 4'b0100, 2'd3, 1'b1);
    cycle();
    exp = {4'b0100, 2'd2, 2'd2, 1'b1};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL lock_setup: got %b expected %b", obs(), exp);
    end
    hreset = 1'b1;
    drive(4'b1111, 4'b1111, 2'd3, 1'b0);
    cycle();
    exp = {4'b0001, 2'd0, 2'd0, 1'b0};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL reset_in_lock: got %b expected %b", obs(), exp);
    end
    hreset = 1'b0;
    drive(4'b1000, 4'b0000, 2'd0, 1'b1);
    cycle();
    exp = {4'b1000, 2'd3, 2'd0, 1'b0};
    n_checks++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL first_arb_after_reset: got %b expected %b", obs(), exp);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] prev, want;
    do_reset();
    bus.prio = {3'd3, 3'd3, 3'd3, 3'd3};
    prev = 2'd0;
    for (int s = 0; s < 8; s++) begin
      drive(4'b1111, 4'b0000, 2'd2, 1'b1);
      cycle();
      want = prev + 2'd1;
      n_checks++;
      if ({bus.hmaster, bus.hmaster_d} !== {want, prev}) begin
        n_fail++;
        $display("FAIL fairness step %0d: got %0d/%0d expected %0d/%0d", s, bus.hmaster, bus.hmaster_d, want, prev);
      end
      prev = want;
    end
  endtask

  task automatic test_random();
    logic [3:0] req;
    do_reset();
    for (int s = 0; s < 600; s++) begin
      req = 4'($urandom);
      for (int m = 0; m < N; m++) bus.prio[m*PB +: PB] = 3'($urandom_range(0, 2));
      drive(req, req & 4'($urandom) & 4'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
      hreset = ($urandom_range(0, 49) == 0);
      cycle();
      n_checks++;
      if (obs() !== model_tuple()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b expected %b", s, obs(), model_tuple());
      end
      n_checks++;
      if (!$onehot(bus.hgrant)) begin
        n_fail++;
        $display("FAIL onehot cycle %0d: got %b expected one-hot", s, bus.hgrant);
      end
    end
    hreset = 1'b0;
  endtask

  initial begin
    bus.prio = '0;
    drive(4'b0000, 4'b0000, 2'd0, 1'b1);
    test_reset();
    test_tie_rr();
    test_seq_hold();
    test_lock();
    test_hready_stall();
    test_reset_in_lock();
    test_fairness();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
